// File: rtl/main_fsm_pkg.sv
// Shared control encodings for the multicycle controller: state names, mux selects
// and the packed control word that the datapath consumes.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] SRCB_WDATA  = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control-word decoder; every field not set for a state stays 0.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      S_FETCH: begin
        ctrl_o.irwrite   = 1'b1;
        ctrl_o.alusrca   = 1'b1;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.resultsrc = RES_ALURESULT;
        ctrl_o.nextpc    = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alusrca   = 1'b1;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.resultsrc = RES_ALURESULT;
      end
      S_MEMADR: begin
        ctrl_o.alusrcb   = SRCB_EXTIMM;
      end
      S_MEMRD: begin
        ctrl_o.adrsrc    = 1'b1;
        ctrl_o.resultsrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.resultsrc = RES_DATA;
        ctrl_o.regw      = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.adrsrc    = 1'b1;
        ctrl_o.resultsrc = RES_ALUOUT;
        ctrl_o.memw      = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_o.alusrcb   = SRCB_WDATA;
        ctrl_o.aluop     = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl_o.alusrcb   = SRCB_EXTIMM;
        ctrl_o.aluop     = 1'b1;
      end
      S_ALUWB: begin
        ctrl_o.resultsrc = RES_ALUOUT;
        ctrl_o.regw      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrcb   = SRCB_EXTIMM;
        ctrl_o.resultsrc = RES_ALURESULT;
        ctrl_o.branch    = 1'b1;
      end
      S_UNKNOWN: ctrl_o = CTRL_IDLE;
      default:   ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle instruction controller: Moore state register plus next-state logic;
// outputs come only from the registered state through main_fsm_outdec.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   unused_funct;

  // Only the immediate and load/store bits steer the sequence.
  assign unused_funct = ^Funct[4:1];

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  main_fsm_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign IRWrite   = ctrl.irwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign NextPC    = ctrl.nextpc;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.aluop;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed and random instructions compared cycle by cycle
// against a step-list model of each instruction class.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcB, ResultSrc;

  int checks = 0;
  int errors = 0;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp)
  );

  always #5 clk = ~clk;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
  logic [12:0] obs;
  assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};

  function automatic logic [12:0] exp_word(input string s);
    case (s)
      "FETCH":    return 13'b1_0_1_10_10_1_0_0_0_0;
      "DECODE":   return 13'b0_0_1_10_10_0_0_0_0_0;
      "MEMADR":   return 13'b0_0_0_01_00_0_0_0_0_0;
      "MEMRD":    return 13'b0_1_0_00_00_0_0_0_0_0;
      "MEMWB":    return 13'b0_0_0_00_01_0_1_0_0_0;
      "MEMWR":    return 13'b0_1_0_00_00_0_0_1_0_0;
      "EXECUTER": return 13'b0_0_0_00_00_0_0_0_0_1;
      "EXECUTEI": return 13'b0_0_0_01_00_0_0_0_0_1;
      "ALUWB":    return 13'b0_0_0_00_00_0_1_0_0_0;
      "BRANCH":   return 13'b0_0_0_01_10_0_0_0_1_0;
      default:    return 13'b0;
    endcase
  endfunction

  task automatic check_word(input string tag, input logic [12:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Runs one instruction from its FETCH cycle; entered and left just after a falling edge.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input bit abort_in_memwr,
                           input int idx);
    string stages[$];
    stages = {"FETCH", "DECODE"};
    case (op)
      2'b00: begin
        stages.push_back(funct[5] ? "EXECUTEI" : "EXECUTER");
        stages.push_back("ALUWB");
      end
      2'b01: begin
        stages.push_back("MEMADR");
        if (funct[0]) begin
          stages.push_back("MEMRD");
          stages.push_back("MEMWB");
        end else begin
          stages.push_back("MEMWR");
        end
      end
      2'b10:   stages.push_back("BRANCH");
      default: stages.push_back("UNKNOWN");
    endcase
    foreach (stages[i]) begin
      check_word($sformatf("i%0d_%s", idx, stages[i]), exp_word(stages[i]));
      checks++;
      assert (ResultSrc !== 2'b11) else begin
        errors++;
        $error("FAIL i%0d_resultsrc_legal: observed %b required not 11", idx, ResultSrc);
      end
      if (abort_in_memwr && stages[i] == "MEMWR") begin
        #2 reset = 1'b1;
        #1 check_word("reset_async_fetch", exp_word("FETCH"));
        @(posedge clk);
        @(negedge clk);
        check_word("reset_held_fetch", exp_word("FETCH"));
        reset = 1'b0;
        return;
      end
      if (stages[i] == "DECODE" || stages[i] == "MEMADR") begin
        Op = op;
        Funct = funct;
      end else begin
        Op = 2'($urandom);
        Funct = 6'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rop;
    logic [5:0] rfn;
    #1 reset = 1'b1;
    #2 check_word("reset_async", exp_word("FETCH"));
    @(negedge clk);
    check_word("reset_after_edge", exp_word("FETCH"));
    reset = 1'b0;

    run_instr(2'b00, 6'b000000, 1'b0, 0);  // register ADD
    run_instr(2'b00, 6'b100100, 1'b0, 1);  // immediate data-processing
    run_instr(2'b01, 6'b000001, 1'b0, 2);  // LDR
    run_instr(2'b01, 6'b000000, 1'b0, 3);  // STR
    run_instr(2'b10, 6'b101010, 1'b0, 4);  // branch
    run_instr(2'b11, 6'b111111, 1'b0, 5);  // undefined
    run_instr(2'b01, 6'b011110, 1'b1, 6);  // store aborted by reset in MEMWR
    run_instr(2'b01, 6'b110011, 1'b0, 7);  // load straight after reset release

    for (int n = 0; n < 300; n++) begin
      rop = 2'($urandom);
      rfn = 6'($urandom);
      run_instr(rop, rfn, 1'b0, 100 + n);
    end
    check_word("final_fetch", exp_word("FETCH"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces FETCH immediately, independent of clk.
REQ-004 Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  in  6  instruction function field; bit5 = immediate (I), bit0 = load/store (L).
REQ-006 IRWrite  out  1  instruction-register load enable.
REQ-007 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 ALUSrcA  out  1  SrcA select: 0 = register A, 1 = PC.
REQ-009 ALUSrcB  out  2  SrcB select: 00 = WriteData, 01 = ExtImm, 10 = constant 4.
REQ-010 ResultSrc  out  2  select for the 3-input result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-011 NextPC  out  1  PC update request.
REQ-012 RegW  out  1  register-write request, before condition gating.
REQ-013 MemW  out  1  memory-write request, before condition gating.
REQ-014 Branch  out  1  branch request, before condition gating.
REQ-015 ALUOp  out  1  1 = ALU decoder uses Funct; 0 = ALU adds.

Function
REQ-016 Moore machine; outputs depend only on the registered state. There is no combinational path from Op or Funct to any output.
REQ-017 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
REQ-018 Unconditional transitions:
- FETCH->DECODE
- MEMRD->MEMWB
- MEMWB->FETCH
- MEMWR->FETCH
- EXECUTER->ALUWB
- EXECUTEI->ALUWB
- ALUWB->FETCH
- BRANCH->FETCH
- UNKNOWN->FETCH
REQ-019 DECODE transitions on Op/Funct sampled at the clock edge:
- Op=00, Funct[5]=0 -> EXECUTER
- Op=00, Funct[5]=1 -> EXECUTEI
- Op=01 -> MEMADR
- Op=10 -> BRANCH
- Op=11 -> UNKNOWN
REQ-020 MEMADR transitions: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
REQ-021 Outputs not listed for a state SHALL be 0 in that state. Per-state outputs:
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
- UNKNOWN: all outputs 0.
REQ-022 ResultSrc SHALL never be 11 in any state.
REQ-023 Latency in cycles, counted from FETCH inclusive:
- data-processing: 4
- load: 5
- store: 4
- branch: 3
- undefined: 3
REQ-024 Any unencoded or illegal state value SHALL return to FETCH on the next edge, with all outputs 0 while in it.
REQ-025 Op and Funct are ignored in every state except DECODE and MEMADR.

Reset
REQ-026 While reset=1, state=FETCH, so IRWrite=1 and NextPC=1. Downstream gating on reset is the datapath's responsibility.
REQ-027 Reset asserted mid-instruction aborts that instruction in the same cycle. No RegW or MemW pulse SHALL follow reset deassertion until the new sequence reaches a write state.
REQ-028 First edge after reset release: FETCH->DECODE.

Structure
REQ-029 The state enumeration and the ALUSrcB and ResultSrc encodings SHALL be defined in a shared control package, and the datapath muxes SHALL use the same constants.
REQ-030 The block SHALL contain exactly one sub-module, main_fsm_outdec: a combinational state-to-control-word decoder. The state register and next-state logic remain in main_fsm.

Verification
REQ-031 Reset pulse mid-MEMWR, then release -> MemW drops asynchronously, state=FETCH, IRWrite=1, then DECODE on the next edge.
REQ-032 Op=00, Funct=000000 (register ADD) -> FETCH, DECODE, EXECUTER, ALUWB with ResultSrc=00, RegW=1 in ALUWB, then FETCH.
REQ-033 Op=01, Funct=000001 (LDR) -> MEMADR (ALUSrcB=01), MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1); 5 cycles total.
REQ-034 Op=01, Funct=000000 (STR) -> MEMADR, then MEMWR with MemW=1 for exactly 1 cycle; RegW=0 throughout.
REQ-035 Op=10 -> BRANCH with Branch=1, ResultSrc=10, ALUSrcB=01; Op=11 -> UNKNOWN with all outputs 0, then FETCH.
REQ-036 Toggle Op and Funct randomly during all non-DECODE and non-MEMADR cycles -> state sequence is unchanged.
